nios2os_avalon_st_adapter_data_format_adapter_0: RTL

Downstream stage of the Avalon-ST adapter timing-adapter FIFO. It consumes the FIFO's 42-bit packed beats (32-bit data plus packet sideband) and serialises each beat into 8-bit symbols, most-significant byte first. It honours `empty` on end-of-packet beats and tracks packet framing. The block feeds the byte-wide sink of the adapter chain and exposes a delivered-packet counter and a sticky framing-error flag.

---
 rtl/nios2os_avalon_st_adapter_data_format_adapter_0_if.sv | 39 +++
 rtl/nios2os_avalon_st_adapter_data_format_adapter_0.sv | 101 ++++++++++
 2 files changed

// File: rtl/nios2os_avalon_st_adapter_data_format_adapter_0_if.sv
// Avalon-ST link carried through the data-format adapter.
// Sink side : in_valid / in_ready / in_data (packed beat:
//             {error, empty, eop, sop, data}).
// Source side: out_valid / out_ready / out_data plus the sop, eop and error
//             sideband for each symbol.
// Modports  : slave  - the adapter (consumes beats, produces symbols).
//             master - the environment (produces beats, consumes symbols).
interface nios2os_avalon_st_adapter_data_format_adapter_0_if #(
  parameter int SYMBOLS  = 4,
  parameter int SYMBOL_W = 8,
  parameter int ERROR_W  = 6
);
  localparam int EMPTY_W = $clog2(SYMBOLS);
  localparam int IN_W    = SYMBOLS*SYMBOL_W + 2 + EMPTY_W + ERROR_W;

  logic                in_ready;
  logic                in_valid;
  logic [IN_W-1:0]     in_data;
  logic                out_ready;
  logic                out_valid;
  logic [SYMBOL_W-1:0] out_data;
  logic                out_startofpacket;
  logic                out_endofpacket;
  logic [ERROR_W-1:0]  out_error;

  modport slave (
    output in_ready,
    input  in_valid, in_data,
    input  out_ready,
    output out_valid, out_data, out_startofpacket, out_endofpacket, out_error
  );

  modport master (
    input  in_ready,
    output in_valid, in_data,
    output out_ready,
    input  out_valid, out_data, out_startofpacket, out_endofpacket, out_error
  );
endinterface

// File: rtl/nios2os_avalon_st_adapter_data_format_adapter_0.sv
// Beat-to-symbol serialiser at the tail of the Avalon-ST adapter chain.
// Takes one 42-bit packed beat at a time (32-bit data + sop/eop/empty/error),
// emits it as 8-bit symbols MSB-first, trimming the tail on eop beats by
// `empty`. Tracks packet framing and counts delivered packets.
// Ports:
//   clk, reset - single clock, asynchronous active-high reset
//   st         - beat sink / symbol source (slave modport)
//   pkt_count  - packets whose eop symbol was accepted (wraps)
//   frame_err  - sticky: sop missing at packet start, or sop inside a packet
module nios2os_avalon_st_adapter_data_format_adapter_0 #(
  parameter int SYMBOLS  = 4,
  parameter int SYMBOL_W = 8,
  parameter int ERROR_W  = 6
) (
  input  logic clk,
  input  logic reset,
  nios2os_avalon_st_adapter_data_format_adapter_0_if.slave st,
  output logic [15:0] pkt_count,
  output logic        frame_err
);
  localparam int IDX_W = $clog2(SYMBOLS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SYMBOLS-1);

  // Field order matches the packed in_data layout, so the beat casts directly.
  typedef struct packed {
    logic [ERROR_W-1:0]               err;
    logic [IDX_W-1:0]                 empty;
    logic                             eop;
    logic                             sop;
    logic [SYMBOLS-1:0][SYMBOL_W-1:0] data;  // [SYMBOLS-1] is byte 0
  } beat_t;

  typedef enum logic {IDLE, IN_PKT} fsm_t;

  beat_t            in_beat, hold;
  logic             hold_valid;
  logic [IDX_W-1:0] idx, last_idx;
  fsm_t             fsm;
  logic             at_last, xfer, retire, load, in_ready;

  assign in_beat = beat_t'(st.in_data);
  assign at_last = (idx == last_idx);
  assign xfer    = hold_valid && st.out_ready;
  assign retire  = xfer && at_last;

  // Combinational from out_ready so the next beat loads on the same edge the
  // last symbol of the current one leaves.
  assign in_ready    = !hold_valid || (st.out_ready && at_last);
  assign st.in_ready = in_ready;
  assign load        = st.in_valid && in_ready;

  assign st.out_valid         = hold_valid;
  assign st.out_data          = hold.data[LAST - idx];
  assign st.out_startofpacket = hold.sop && (idx == '0);
  assign st.out_endofpacket   = hold.eop && at_last;
  assign st.out_error         = hold.err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      idx        <= '0;
      last_idx   <= '0;
      pkt_count  <= '0;
    end else begin
      if (load) begin
        hold       <= in_beat;
        // empty only trims the final beat of a packet
        last_idx   <= in_beat.eop ? LAST - in_beat.empty : LAST;
        hold_valid <= 1'b1;
        idx        <= '0;
      end else if (retire) begin
        hold_valid <= 1'b0;
        idx        <= '0;
      end else if (xfer) begin
        idx <= idx + IDX_W'(1);
      end
      if (xfer && st.out_endofpacket) pkt_count <= pkt_count + 16'd1;
    end
  end

  // Framing is judged per loaded beat; offending beats still pass through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm       <= IDLE;
      frame_err <= 1'b0;
    end else if (load) begin
      case (fsm)
        IDLE: begin
          if (!in_beat.sop) frame_err <= 1'b1;
          if (in_beat.sop && !in_beat.eop) fsm <= IN_PKT;
        end
        IN_PKT: begin
          if (in_beat.sop) frame_err <= 1'b1;
          if (in_beat.eop) fsm <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule
